// File: rtl/accum_sequencer_pkg.sv
// Shared definitions for the accumulator sequencer.
//   ACC_WIDTH_DEFAULT : default operand/accumulator width
//   CNT_W             : width of the completed-operation counter
//   state_t           : sequencer FSM state type
package accum_sequencer_pkg;

    localparam int unsigned ACC_WIDTH_DEFAULT = 4;
    localparam int unsigned CNT_W             = 4;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StDone
    } state_t;

endpackage

// File: rtl/accum_sequencer.sv
// Accumulator sequencer. It accepts one command at a time, drives the accumulator
// and the latched operand to an external add/sub stage, captures that stage's
// result and flags, and then holds the result until downstream accepts it.
//
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   in_valid/in_ready   command handshake (in_b operand, in_mode 0=add 1=sub,
//                       in_clr clears accumulator and sticky overflow)
//   a_out/b_out/mode_out  operands and mode driven to the arithmetic stage
//   ans_in/v_in/c_in    arithmetic stage result, overflow, carry/borrow
//   out_valid/out_ready result handshake
//   out_acc/out_v/out_c result accumulator and flags of the last operation
//   out_ovf             sticky overflow since the last clear
//   op_cnt              completed-operation count, wraps modulo 16
module accum_sequencer
    import accum_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = ACC_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_mode,
    input  logic             in_clr,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             mode_out,
    input  logic [WIDTH-1:0] ans_in,
    input  logic             v_in,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_acc,
    output logic             out_v,
    output logic             out_c,
    output logic             out_ovf,
    output logic [CNT_W-1:0] op_cnt
);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_b;
    logic             r_mode;
    logic             r_clr;
    logic             r_v;
    logic             r_c;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;
    logic             w_idle;
    logic             w_exec;
    logic             w_done;
    logic             w_accept;
    logic             w_handshake;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idle       = 1'b0;
        w_exec       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            StIdle: begin
                w_idle = 1'b1;
                if (in_valid) begin
                    w_state_next = StExec;
                end
            end
            StExec: begin
                w_exec       = 1'b1;
                w_state_next = StDone;
            end
            StDone: begin
                w_done = 1'b1;
                if (out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign w_accept    = w_idle & in_valid;
    assign w_handshake = w_done & out_ready;

    // Handshake outputs are masked while reset is asserted so nothing is offered
    // or accepted during the reset cycle itself.
    assign in_ready  = w_idle & rst_n;
    assign out_valid = w_done & rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_b    <= '0;
            r_mode <= 1'b0;
            r_clr  <= 1'b0;
            r_v    <= 1'b0;
            r_c    <= 1'b0;
            r_ovf  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_b    <= in_b;
                r_mode <= in_mode;
                r_clr  <= in_clr;
            end
            if (w_exec) begin
                if (r_clr) begin
                    r_acc <= '0;
                    r_v   <= 1'b0;
                    r_c   <= 1'b0;
                    r_ovf <= 1'b0;
                end else begin
                    r_acc <= ans_in;
                    r_v   <= v_in;
                    r_c   <= c_in;
                    r_ovf <= r_ovf | v_in;
                end
            end
            if (w_handshake) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign a_out    = r_acc;
    assign b_out    = r_b;
    assign mode_out = r_mode;
    assign out_acc  = r_acc;
    assign out_v    = r_v;
    assign out_c    = r_c;
    assign out_ovf  = r_ovf;
    assign op_cnt   = r_cnt;

endmodule

// File: tb/tb_accum_sequencer.sv
// Self-checking bench for accum_sequencer with a 4-bit add/sub stage on the
// arithmetic path, a scoreboard queue and a handshake-driven monitor.
module tb_accum_sequencer;

    localparam int unsigned W = 4;

    typedef struct {
        logic [3:0] acc;
        logic       v;
        logic       c;
        logic       ovf;
        logic [3:0] cnt;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_b;
    logic         in_mode;
    logic         in_clr;
    logic [W-1:0] a_out;
    logic [W-1:0] b_out;
    logic         mode_out;
    logic [W-1:0] ans_in;
    logic         v_in;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_acc;
    logic         out_v;
    logic         out_c;
    logic         out_ovf;
    logic [3:0]   op_cnt;

    int   checks;
    int   failures;
    exp_t sb_q[$];
    bit   g_rand;

    // Reference model state, kept as plain integers.
    int m_acc;
    int m_ovf;
    int m_cnt;

    accum_sequencer #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_b     (in_b),
        .in_mode  (in_mode),
        .in_clr   (in_clr),
        .a_out    (a_out),
        .b_out    (b_out),
        .mode_out (mode_out),
        .ans_in   (ans_in),
        .v_in     (v_in),
        .c_in     (c_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_acc  (out_acc),
        .out_v    (out_v),
        .out_c    (out_c),
        .out_ovf  (out_ovf),
        .op_cnt   (op_cnt)
    );

    // 4-bit add/sub stage: C is carry for add, borrow for subtract.
    logic [4:0] w_sum;
    always_comb begin
        w_sum = 5'd0;
        v_in  = 1'b0;
        if (!mode_out) begin
            w_sum = {1'b0, a_out} + {1'b0, b_out};
            v_in  = (a_out[3] == b_out[3]) && (w_sum[3] != a_out[3]);
        end else begin
            w_sum = {1'b0, a_out} - {1'b0, b_out};
            v_in  = (a_out[3] != b_out[3]) && (w_sum[3] != a_out[3]);
        end
    end
    assign ans_in = w_sum[3:0];
    assign c_in   = w_sum[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int to_signed4(input int u);
        return (u >= 8) ? u - 16 : u;
    endfunction

    // Expected result of one command, computed from the arithmetic rules.
    task automatic model_push(input int b, input bit mode, input bit clr);
        exp_t e;
        int   s;
        int   u;
        e.cnt = m_cnt[3:0];
        if (clr) begin
            m_acc = 0;
            m_ovf = 0;
            e.v   = 1'b0;
            e.c   = 1'b0;
        end else begin
            if (!mode) begin
                u   = m_acc + b;
                s   = to_signed4(m_acc) + to_signed4(b);
                e.c = (u > 15);
            end else begin
                u   = m_acc - b;
                s   = to_signed4(m_acc) - to_signed4(b);
                e.c = (m_acc < b);
            end
            e.v   = (s > 7) || (s < -8);
            m_acc = ((u % 16) + 16) % 16;
            if (e.v) m_ovf = 1;
        end
        e.acc = m_acc[3:0];
        e.ovf = (m_ovf != 0);
        m_cnt = (m_cnt + 1) % 16;
        sb_q.push_back(e);
    endtask

    task automatic model_reset();
        m_acc = 0;
        m_ovf = 0;
        m_cnt = 0;
        sb_q.delete();
    endtask

    // Monitor: every result handshake pops and checks one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("out_acc", 32'(out_acc), 32'(e.acc));
                chk("out_v",   32'(out_v),   32'(e.v));
                chk("out_c",   32'(out_c),   32'(e.c));
                chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
                chk("op_cnt",  32'(op_cnt),  32'(e.cnt));
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 100; i++) begin
            if (in_ready) return;
            @(posedge clk);
            #1;
            if (g_rand) out_ready = 1'($urandom_range(0, 1));
        end
        chk("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    // Issue one command and check acceptance, EXEC operands and latency.
    task automatic send(input int b, input bit mode, input bit clr);
        int prev_acc;
        wait_ready();
        prev_acc = m_acc;
        in_valid = 1'b1;
        in_b     = b[3:0];
        in_mode  = mode;
        in_clr   = clr;
        @(posedge clk);
        model_push(b, mode, clr);
        #1;
        in_valid = 1'b0;
        in_b     = 4'($urandom);
        in_mode  = 1'($urandom);
        in_clr   = 1'($urandom);
        chk("exec_in_ready",  32'(in_ready),  32'd0);
        chk("exec_out_valid", 32'(out_valid), 32'd0);
        chk("exec_a_out",     32'(a_out),     32'(prev_acc));
        chk("exec_b_out",     32'(b_out),     32'(b));
        chk("exec_mode_out",  32'(mode_out),  32'(mode));
        @(posedge clk);
        #1;
        chk("done_out_valid", 32'(out_valid), 32'd1);
        chk("done_in_ready",  32'(in_ready),  32'd0);
        if (g_rand) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0 && in_ready) return;
        end
        chk("drain_timeout", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        g_rand    = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_b      = '0;
        in_mode   = 1'b0;
        in_clr    = 1'b0;
        out_ready = 1'b1;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_acc",   32'(out_acc),   32'd0);
        chk("rst_op_cnt",    32'(op_cnt),    32'd0);
        chk("rst_flags",     32'({out_v, out_c, out_ovf}), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // clr, +3, +4
        send(0, 1'b0, 1'b1);
        send(3, 1'b0, 1'b0);
        send(4, 1'b0, 1'b0);
        drain();
        chk("seq_acc",   32'(out_acc), 32'd7);
        chk("seq_v",     32'(out_v),   32'd0);
        chk("seq_c",     32'(out_c),   32'd0);
        chk("seq_ovf",   32'(out_ovf), 32'd0);
        chk("seq_opcnt", 32'(op_cnt),  32'd3);

        // 7 + 1 overflows, then +0 clears V but not the sticky flag
        send(1, 1'b0, 1'b0);
        drain();
        chk("ovf_acc", 32'(out_acc), 32'd8);
        chk("ovf_v",   32'(out_v),   32'd1);
        chk("ovf_ovf", 32'(out_ovf), 32'd1);
        send(0, 1'b0, 1'b0);
        drain();
        chk("sticky_v",   32'(out_v),   32'd0);
        chk("sticky_ovf", 32'(out_ovf), 32'd1);

        // 0 - 1 borrows
        send(0, 1'b0, 1'b1);
        send(1, 1'b1, 1'b0);
        drain();
        chk("sub_acc", 32'(out_acc), 32'd15);
        chk("sub_c",   32'(out_c),   32'd1);
        chk("sub_v",   32'(out_v),   32'd0);

        // Back-pressure in DONE for 5 cycles with ignored in_valid pulses
        out_ready = 1'b0;
        send(2, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready",  32'(in_ready),  32'd0);
            chk("stall_acc",       32'(out_acc),   32'(sb_q[0].acc));
            chk("stall_c",         32'(out_c),     32'(sb_q[0].c));
            chk("stall_v",         32'(out_v),     32'(sb_q[0].v));
            chk("stall_ovf",       32'(out_ovf),   32'(sb_q[0].ovf));
            chk("stall_op_cnt",    32'(op_cnt),    32'(sb_q[0].cnt));
            in_valid = 1'($urandom_range(0, 1));
            in_b     = 4'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();
        chk("stall_final_acc", 32'(out_acc), 32'd1);

        // Randomized traffic with random downstream back-pressure
        g_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(int'($urandom_range(0, 15)), 1'($urandom), ($urandom_range(0, 7) == 0));
        end
        g_rand = 1'b0;
        drain();

        // Reset during EXEC aborts the operation
        send(5, 1'b0, 1'b0);
        drain();
        wait_ready();
        in_valid = 1'b1;
        in_b     = 4'd6;
        in_mode  = 1'b0;
        in_clr   = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("abort_rst_in_ready",  32'(in_ready),  32'd0);
        chk("abort_rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("abort_acc",   32'(out_acc), 32'd0);
        chk("abort_flags", 32'({out_v, out_c, out_ovf}), 32'd0);
        chk("abort_cnt",   32'(op_cnt),  32'd0);
        chk("abort_ports", 32'({a_out, b_out, mode_out}), 32'd0);
        model_reset();
        rst_n = 1'b1;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);

        // 16 completed operations wrap op_cnt back to 0
        g_rand = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(int'($urandom_range(0, 15)), 1'($urandom), 1'b0);
        end
        g_rand = 1'b0;
        drain();
        chk("wrap_op_cnt", 32'(op_cnt), 32'd0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
